// File: rtl/noc_eject_sink.sv
// noc_eject_sink
// Ejection-side collector for the 4x4 torus NoC. Sixteen nodes present
// 16-bit packets on their ejection lanes; a round-robin arbiter accepts
// at most one per cycle into a FIFO that feeds a single output stream.
// Each accepted packet is tagged when its destination field does not
// match the coordinates of the node that ejected it.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high
//   ejection   node i packet on [16i+15:16i]
//   EJ_req     per-node valid
//   EJ_ans     one-hot accept (combinational), zero when full or in reset
//   out_data   packet at FIFO head
//   out_src    ejecting node index of the head packet
//   out_err    head packet destination mismatch
//   out_valid  FIFO non-empty
//   out_ready  consumer takes the head when out_valid & out_ready
//   rx_count   accepted packets since reset, saturating
//   err_count  misrouted packets accepted since reset, saturating
module noc_eject_sink #(
   parameter int LL    = 16,
   parameter int DEPTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [LL*LL-1:0] ejection,
   input  logic [LL-1:0]    EJ_req,
   output logic [LL-1:0]    EJ_ans,
   output logic [LL-1:0]    out_data,
   output logic [3:0]       out_src,
   output logic             out_err,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [15:0]      rx_count,
   output logic [15:0]      err_count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [3:0]    ptr_q, ptr_d;
   logic [AW-1:0] wrPtr_q, wrPtr_d;
   logic [AW-1:0] rdPtr_q, rdPtr_d;
   logic [AW:0]   count_q, count_d;
   logic [15:0]   rxCount_q, rxCount_d;
   logic [15:0]   errCount_q, errCount_d;

   logic [LL-1:0] dataMem [DEPTH];
   logic [3:0]    srcMem  [DEPTH];
   logic          errMem  [DEPTH];

   logic          grantFound;
   logic [3:0]    grantIdx;
   logic [3:0]    scanIdx;
   logic          doGrant;
   logic          doPop;
   logic [LL-1:0] grantPkt;
   logic          grantErr;

   // Round-robin search: walk the nodes starting at the pointer and take
   // the first requester. The pointer is 4 bits so the walk wraps 15 -> 0.
   always_comb begin
      grantFound = 1'b0;
      grantIdx   = '0;
      scanIdx    = '0;
      for (int k = 0; k < LL; k++) begin
         scanIdx = ptr_q + 4'(k);
         if (!grantFound && EJ_req[scanIdx]) begin
            grantFound = 1'b1;
            grantIdx   = scanIdx;
         end
      end
   end

   // Accept only with room in the FIFO as it stands before the edge, so a
   // pop on a full FIFO frees the slot for the following cycle only.
   // Packet coordinates are checked against the node index {y,x}.
   always_comb begin
      doGrant  = grantFound && (count_q != FULL_CNT) && !reset;
      doPop    = (count_q != '0) && out_ready;
      grantPkt = ejection[grantIdx*LL +: LL];
      grantErr = (grantPkt[15:14] != grantIdx[1:0]) |
                 (grantPkt[13:12] != grantIdx[3:2]);
      EJ_ans   = doGrant ? ({{(LL-1){1'b0}}, 1'b1} << grantIdx) : '0;
   end

   // Next-state for pointers, occupancy and the saturating counters.
   always_comb begin
      ptr_d      = ptr_q;
      wrPtr_d    = wrPtr_q;
      rdPtr_d    = rdPtr_q;
      count_d    = count_q;
      rxCount_d  = rxCount_q;
      errCount_d = errCount_q;
      if (doGrant) begin
         ptr_d   = grantIdx + 4'd1;
         wrPtr_d = wrPtr_q + AW'(1);
         if (rxCount_q != 16'hFFFF) begin
            rxCount_d = rxCount_q + 16'd1;
         end
         if (grantErr && (errCount_q != 16'hFFFF)) begin
            errCount_d = errCount_q + 16'd1;
         end
      end
      if (doPop) begin
         rdPtr_d = rdPtr_q + AW'(1);
      end
      case ({doGrant, doPop})
         2'b10:   count_d = count_q + (AW+1)'(1);
         2'b01:   count_d = count_q - (AW+1)'(1);
         default: count_d = count_q;
      endcase
   end

   // Control state; reset discards the FIFO by clearing the pointers.
   always_ff @(posedge clk) begin
      if (reset) begin
         ptr_q      <= '0;
         wrPtr_q    <= '0;
         rdPtr_q    <= '0;
         count_q    <= '0;
         rxCount_q  <= '0;
         errCount_q <= '0;
      end else begin
         ptr_q      <= ptr_d;
         wrPtr_q    <= wrPtr_d;
         rdPtr_q    <= rdPtr_d;
         count_q    <= count_d;
         rxCount_q  <= rxCount_d;
         errCount_q <= errCount_d;
      end
   end

   // FIFO storage needs no reset; only entries below the occupancy count
   // are ever presented as valid.
   always_ff @(posedge clk) begin
      if (doGrant) begin
         dataMem[wrPtr_q] <= grantPkt;
         srcMem[wrPtr_q]  <= grantIdx;
         errMem[wrPtr_q]  <= grantErr;
      end
   end

   // The head entry is exposed directly from storage.
   always_comb begin
      out_data  = dataMem[rdPtr_q];
      out_src   = srcMem[rdPtr_q];
      out_err   = errMem[rdPtr_q];
      out_valid = (count_q != '0);
      rx_count  = rxCount_q;
      err_count = errCount_q;
   end

endmodule

// File: tb/tb_noc_eject_sink.sv
// tb_noc_eject_sink
// Self-checking bench for noc_eject_sink. A reference model tracks the
// round-robin pointer, a scoreboard queue of accepted packets and the
// saturating counters; every cycle the DUT is compared against it. A
// table of single-packet vectors and hand-written sequences cover
// misrouting, round robin, backpressure, mid-run reset and saturation.
module tb_noc_eject_sink;

   localparam int DEPTH = 8;

   typedef struct {
      logic        err;
      logic [3:0]  src;
      logic [15:0] data;
   } entry_t;

   typedef struct {
      int          node;
      logic [15:0] pkt;
      logic [15:0] expAns;
      logic        expErr;
   } vec_t;

   logic          clk;
   logic          reset;
   logic [255:0]  ejection;
   logic [15:0]   EJ_req;
   logic [15:0]   EJ_ans;
   logic [15:0]   out_data;
   logic [3:0]    out_src;
   logic          out_err;
   logic          out_valid;
   logic          out_ready;
   logic [15:0]   rx_count;
   logic [15:0]   err_count;

   logic [15:0]   pkts [16];
   entry_t        sbq [$];
   vec_t          vecs [6];
   logic [3:0]    mPtr;
   logic [15:0]   mRx;
   logic [15:0]   mErr;
   logic [15:0]   expAnsModel;
   logic [15:0]   oneHot;
   bit            quiet;
   int            checks;
   int            errors;
   int            grantCount;

   noc_eject_sink #(.LL(16), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .reset     (reset),
      .ejection  (ejection),
      .EJ_req    (EJ_req),
      .EJ_ans    (EJ_ans),
      .out_data  (out_data),
      .out_src   (out_src),
      .out_err   (out_err),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .rx_count  (rx_count),
      .err_count (err_count)
   );

   // Free-running clock, period 10.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Pack the per-node packets onto the flat ejection bus.
   always_comb begin
      ejection = '0;
      for (int i = 0; i < 16; i++) begin
         ejection[16*i +: 16] = pkts[i];
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Every node gets a correctly addressed packet: x = i[1:0], y = i[3:2].
   task automatic loadGoodPackets();
      logic [3:0] ni;
      for (int i = 0; i < 16; i++) begin
         ni = i[3:0];
         pkts[i] = {ni[1:0], ni[3:2], 12'h0A0 + 12'(i)};
      end
   endtask

   // Compare the DUT against the model for the current cycle.
   task automatic checkOutput();
      if (!quiet) begin
         check("ejAns", EJ_ans, expAnsModel);
         check("outValid", out_valid, (sbq.size() != 0));
         if (sbq.size() != 0) begin
            check("headData", out_data, sbq[0].data);
            check("headSrc", out_src, sbq[0].src);
            check("headErr", out_err, sbq[0].err);
         end
         check("rxCount", rx_count, mRx);
         check("errCount", err_count, mErr);
      end
   endtask

   // Drive one cycle of inputs at the falling edge, check just after, then
   // advance the model to the state the next rising edge produces.
   task automatic applyStimulus(input logic [15:0] req, input logic rdy, input logic rst);
      bit         found;
      logic [3:0] g;
      logic [3:0] idx;
      logic [15:0] p;
      bit         popNow;
      entry_t     e;
      @(negedge clk);
      EJ_req    = req;
      out_ready = rdy;
      reset     = rst;
      #1;
      found = 0;
      g     = '0;
      if (!rst && sbq.size() < DEPTH) begin
         for (int k = 0; k < 16; k++) begin
            idx = mPtr + 4'(k);
            if (!found && req[idx]) begin
               found = 1;
               g     = idx;
            end
         end
      end
      expAnsModel = found ? (16'h0001 << g) : 16'h0000;
      checkOutput();
      if (rst) begin
         sbq.delete();
         mPtr = '0;
         mRx  = '0;
         mErr = '0;
      end else begin
         popNow = (sbq.size() != 0) && rdy;
         if (popNow) begin
            void'(sbq.pop_front());
         end
         if (found) begin
            p      = pkts[g];
            e.data = p;
            e.src  = g;
            e.err  = (p[15:14] != g[1:0]) || (p[13:12] != g[3:2]);
            sbq.push_back(e);
            mPtr = g + 4'd1;
            if (mRx != 16'hFFFF) mRx = mRx + 16'd1;
            if (e.err && mErr != 16'hFFFF) mErr = mErr + 16'd1;
         end
      end
   endtask

   initial begin
      checks      = 0;
      errors      = 0;
      quiet       = 0;
      reset       = 1'b1;
      EJ_req      = '0;
      out_ready   = 1'b1;
      mPtr        = '0;
      mRx         = '0;
      mErr        = '0;
      expAnsModel = '0;
      oneHot      = 16'h0001;
      loadGoodPackets();

      vecs[0] = '{node: 5,  pkt: 16'h5ABC, expAns: 16'h0020, expErr: 1'b0};
      vecs[1] = '{node: 3,  pkt: 16'h0123, expAns: 16'h0008, expErr: 1'b1};
      vecs[2] = '{node: 0,  pkt: 16'h0FFF, expAns: 16'h0001, expErr: 1'b0};
      vecs[3] = '{node: 15, pkt: 16'hFFFF, expAns: 16'h8000, expErr: 1'b0};
      vecs[4] = '{node: 10, pkt: 16'hA5A5, expAns: 16'h0400, expErr: 1'b0};
      vecs[5] = '{node: 6,  pkt: 16'h6321, expAns: 16'h0040, expErr: 1'b1};

      // Reset state
      applyStimulus(16'h0000, 1'b1, 1'b1);
      applyStimulus(16'h0000, 1'b1, 1'b1);
      applyStimulus(16'h0000, 1'b1, 1'b0);
      check("resetValid", out_valid, 1'b0);
      check("resetRx", rx_count, 16'h0000);
      check("resetErr", err_count, 16'h0000);
      check("resetAns", EJ_ans, 16'h0000);

      // Single-packet vectors, each drained before the next
      for (int v = 0; v < 6; v++) begin
         pkts[vecs[v].node] = vecs[v].pkt;
         applyStimulus(oneHot << vecs[v].node, 1'b1, 1'b0);
         check("vecAns", EJ_ans, vecs[v].expAns);
         applyStimulus(16'h0000, 1'b1, 1'b0);
         check("vecValid", out_valid, 1'b1);
         check("vecData", out_data, vecs[v].pkt);
         check("vecSrc", out_src, vecs[v].node);
         check("vecErr", out_err, vecs[v].expErr);
      end
      applyStimulus(16'h0000, 1'b1, 1'b0);
      check("vecRxTotal", rx_count, 16'd6);
      check("vecErrTotal", err_count, 16'd2);
      loadGoodPackets();

      // Round robin with every node requesting
      applyStimulus(16'h0000, 1'b1, 1'b1);
      for (int k = 0; k < 18; k++) begin
         applyStimulus(16'hFFFF, 1'b1, 1'b0);
         check("rrAns", EJ_ans, oneHot << (k % 16));
         if (k > 0) begin
            check("rrSrc", out_src, (k - 1) % 16);
         end
      end
      applyStimulus(16'h0000, 1'b1, 1'b0);
      applyStimulus(16'h0000, 1'b1, 1'b0);

      // Backpressure until full, then release
      applyStimulus(16'h0000, 1'b1, 1'b1);
      grantCount = 0;
      for (int k = 0; k < 10; k++) begin
         applyStimulus(16'hFFFF, 1'b0, 1'b0);
         if (EJ_ans != 16'h0000) grantCount++;
      end
      check("fullGrants", grantCount, 8);
      check("fullAns", EJ_ans, 16'h0000);
      check("fullValid", out_valid, 1'b1);
      applyStimulus(16'hFFFF, 1'b1, 1'b0);
      check("firstPopAns", EJ_ans, 16'h0000);
      check("firstPopSrc", out_src, 4'd0);
      applyStimulus(16'hFFFF, 1'b1, 1'b0);
      check("afterPopAns", EJ_ans, 16'h0100);
      check("afterPopSrc", out_src, 4'd1);
      for (int k = 0; k < 10; k++) begin
         applyStimulus(16'h0000, 1'b1, 1'b0);
      end
      check("drainedValid", out_valid, 1'b0);

      // Reset with entries queued
      applyStimulus(16'h0000, 1'b1, 1'b1);
      for (int k = 0; k < 5; k++) begin
         applyStimulus(16'hFFFF, 1'b0, 1'b0);
      end
      check("queuedValid", out_valid, 1'b1);
      applyStimulus(16'h0006, 1'b0, 1'b1);
      check("resetHoldAns", EJ_ans, 16'h0000);
      applyStimulus(16'h0006, 1'b0, 1'b0);
      check("midResetValid", out_valid, 1'b0);
      check("midResetRx", rx_count, 16'h0000);
      check("midResetAns", EJ_ans, 16'h0002);
      applyStimulus(16'h0004, 1'b1, 1'b0);
      check("midResetNext", EJ_ans, 16'h0004);
      applyStimulus(16'h0000, 1'b1, 1'b0);
      applyStimulus(16'h0000, 1'b1, 1'b0);

      // Saturation of the receive counter
      applyStimulus(16'h0000, 1'b1, 1'b1);
      quiet = 1;
      for (int k = 0; k < 65540; k++) begin
         applyStimulus(16'hFFFF, 1'b1, 1'b0);
      end
      quiet = 0;
      applyStimulus(16'hFFFF, 1'b1, 1'b0);
      check("rxSaturated", rx_count, 16'hFFFF);
      check("errAfterSat", err_count, 16'h0000);
      applyStimulus(16'h0000, 1'b1, 1'b0);
      applyStimulus(16'h0000, 1'b1, 1'b0);
      check("rxStillSat", rx_count, 16'hFFFF);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
